la_ioseq: RTL

- Power-up/power-down sequencer for the sky130 IO ring.
- Generates the ring-wide control signals that the passive IO cells (pads, corners, fillers) consume: high-voltage enable, VDDA enable, VSWITCH enable and hold.
- Orders them against core/IO power-good indications so that IO cells never leave hold with undefined core-side levels.
- Sits in the core-voltage domain next to the padring; its outputs feed the level-shifted control lanes of the ring.

---
 rtl/la_ioseq.sv | 103 ++++++++++
 1 files changed

// File: rtl/la_ioseq.sv
// la_ioseq: sky130 IO ring power-up/down sequencer ordering enables and hold against power-good.
// Optional hold-retention handshake is enabled by defining LA_IOSEQ_RETENTION_EN.
module la_ioseq #(
  parameter int DLYW     = 8,
  parameter int DLY_IO   = 16,
  parameter int DLY_HOLD = 8
) (
  input  logic clk,
  input  logic nreset,
  input  logic vdd_good,
  input  logic vddio_good,
`ifdef LA_IOSEQ_RETENTION_EN
  input  logic ret_req,
  output logic ret_ack,
`endif
  output logic enable_h,
  output logic enable_vdda_h,
  output logic enable_vswitch_h,
  output logic hld_h_n,
  output logic ready,
  output logic fault
);
`ifdef LA_IOSEQ_RETENTION_EN
  typedef enum logic [2:0] {OFF, STABLE, ENABLE, RELEASE, READY, SHUTDN, RETAIN} state_t;
`else
  typedef enum logic [2:0] {OFF, STABLE, ENABLE, RELEASE, READY, SHUTDN} state_t;
`endif
  localparam logic [DLYW-1:0] IO_LAST   = DLYW'(DLY_IO - 1);
  localparam logic [DLYW-1:0] HOLD_LAST = DLYW'(DLY_HOLD - 1);
  state_t state_q, state_d;
  logic [DLYW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] vdd_s_q, vio_s_q;
  logic pg, en_q, en_d, hld_q, rdy_q, flt_q, flt_d;
  assign pg      = vdd_s_q[1] & vio_s_q[1];
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + DLYW'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      OFF:     state_d = pg ? STABLE : OFF;
      STABLE:  begin
        state_d = !pg ? OFF : (cnt_q == IO_LAST) ? ENABLE : STABLE;
        cnt_d   = (state_d == STABLE) ? cnt_inc : '0;
      end
      ENABLE:  begin
        state_d = !pg ? SHUTDN : (cnt_q == HOLD_LAST) ? RELEASE : ENABLE;
        cnt_d   = (state_d == ENABLE) ? cnt_inc : '0;
      end
      RELEASE: state_d = pg ? READY : SHUTDN;
`ifdef LA_IOSEQ_RETENTION_EN
      READY:   state_d = !pg ? SHUTDN : ret_req ? RETAIN : READY;
      RETAIN:  state_d = !pg ? SHUTDN : ret_req ? RETAIN : RELEASE;
`else
      READY:   state_d = pg ? READY : SHUTDN;
`endif
      SHUTDN:  begin
        state_d = (cnt_q == DLYW'(1)) ? OFF : SHUTDN;
        cnt_d   = (state_d == SHUTDN) ? cnt_inc : '0;
      end
      default: state_d = OFF;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state they describe.
`ifdef LA_IOSEQ_RETENTION_EN
  assign en_d  = (state_d inside {ENABLE, RELEASE, READY, RETAIN}) || (state_d == SHUTDN && cnt_d == '0);
  assign flt_d = flt_q || ((state_q inside {READY, RETAIN}) && state_d == SHUTDN);
  logic ack_q;
  assign ret_ack = ack_q;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) ack_q <= 1'b0;
    else         ack_q <= (state_q == RETAIN) && (state_d == RETAIN);
`else
  assign en_d  = (state_d inside {ENABLE, RELEASE, READY}) || (state_d == SHUTDN && cnt_d == '0);
  assign flt_d = flt_q || (state_q == READY && state_d == SHUTDN);
`endif
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= OFF;
      cnt_q   <= '0;
      vdd_s_q <= '0;
      vio_s_q <= '0;
      en_q    <= 1'b0;
      hld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vdd_s_q <= {vdd_s_q[0], vdd_good};
      vio_s_q <= {vio_s_q[0], vddio_good};
      en_q    <= en_d;
      hld_q   <= (state_d inside {RELEASE, READY});
      rdy_q   <= (state_d == READY);
      flt_q   <= flt_d;
    end
  end
  assign enable_h         = en_q;
  assign enable_vdda_h    = en_q;
  assign enable_vswitch_h = en_q;
  assign hld_h_n          = hld_q;
  assign ready            = rdy_q;
  assign fault            = flt_q;
endmodule
